// File: rtl/cnu_pkg.sv
// Shared definitions for the serial LDPC check-node unit.
// MAG_MAX is the saturated magnitude limit at the default message width;
// modules built for other widths derive the same limit from their own W.
package cnu_pkg;

  localparam int CNU_W   = 32;
  localparam int CNU_DEG = 6;

  localparam logic [CNU_W-1:0] MAG_MAX = {1'b0, {(CNU_W-1){1'b1}}};

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/cnu_abs_sat.sv
// Signed two's complement to saturated magnitude.
// Latency: combinational. Backpressure: none, pure function of q.
// Ports: q (W-bit signed message) -> mag (W-bit magnitude, never above 2^(W-1)-1).
module cnu_abs_sat
  import cnu_pkg::*;
#(
  parameter int W = CNU_W
) (
  input  logic [W-1:0] q,
  output logic [W-1:0] mag
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAG_LIM  = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    mag = q;
    if (q[W-1]) begin
      // The most negative value has no positive twin; clamp it.
      if (q == MOST_NEG) mag = MAG_LIM;
      else               mag = ~q + W'(1);
    end
  end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check-node unit: collects DEG Q messages, then emits DEG R messages in arrival order.
// Latency: first R valid the cycle after the DEG-th Q is accepted; one R per cycle while out_ready is high.
// Backpressure: in_ready is low for the whole emit phase; out_ready low holds out_r/out_last/out-index.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_q (Q stream);
//        out_valid/out_ready/out_r/out_last (R stream); parity_ok (syndrome of last completed check).
module cnu_serial
  import cnu_pkg::*;
#(
  parameter int DEG = CNU_DEG,
  parameter int W   = CNU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_last,
  output logic         parity_ok
);

  localparam int              IW      = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [IW-1:0]   LAST    = IW'(DEG - 1);
  localparam logic [W-1:0]    MAG_LIM = {1'b0, {(W-1){1'b1}}};

  state_t          state, state_nxt;
  logic [DEG-1:0]  signs;
  logic            sign_total;
  logic [W-1:0]    min1, min2;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   in_idx, out_idx;

  logic [W-1:0]    in_mag;
  logic            in_sign;
  logic            in_fire, out_fire;
  logic [W-1:0]    out_mag;
  logic            out_sign;

  cnu_abs_sat #(.W(W)) u_abs_sat (
    .q   (in_q),
    .mag (in_mag)
  );

  assign in_sign = in_q[W-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && (in_idx == LAST)) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && (out_idx == LAST)) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Running min1/min2/idx, sign accumulation and indices
  always_ff @(posedge clk) begin
    if (rst) begin
      signs      <= '0;
      sign_total <= 1'b0;
      min1       <= MAG_LIM;
      min2       <= MAG_LIM;
      idx        <= '0;
      in_idx     <= '0;
      out_idx    <= '0;
      parity_ok  <= 1'b0;
    end else if (in_fire) begin
      signs[in_idx] <= in_sign;
      sign_total    <= sign_total ^ in_sign;
      // Strict compares keep the first occurrence on ties and let min2 equal min1.
      if (in_mag < min1) begin
        min2 <= min1;
        min1 <= in_mag;
        idx  <= in_idx;
      end else if (in_mag < min2) begin
        min2 <= in_mag;
      end
      if (in_idx == LAST) begin
        in_idx    <= '0;
        out_idx   <= '0;
        parity_ok <= ~(sign_total ^ in_sign);
      end else begin
        in_idx <= in_idx + IW'(1);
      end
    end else if (out_fire) begin
      if (out_idx == LAST) begin
        // Check fully drained: re-arm for the next one on this same edge.
        signs      <= '0;
        sign_total <= 1'b0;
        min1       <= MAG_LIM;
        min2       <= MAG_LIM;
        idx        <= '0;
        in_idx     <= '0;
        out_idx    <= '0;
      end else begin
        out_idx <= out_idx + IW'(1);
      end
    end
  end

  // R for position j excludes Q_j: its own sign is XORed back out of the total,
  // and the minimum holder gets the second minimum.
  always_comb begin
    out_mag  = (out_idx == idx) ? min2 : min1;
    out_sign = sign_total ^ signs[out_idx];
    out_r    = '0;
    out_last = 1'b0;
    if (state == EMIT) begin
      out_r    = out_sign ? (~out_mag + W'(1)) : out_mag;
      out_last = (out_idx == LAST);
    end
  end

endmodule

// File: tb/tb_cnu_serial.sv
module tb_cnu_serial;

  localparam int W   = 32;
  localparam int DEG = 6;

  typedef logic [W-1:0] qarr_t [DEG];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic         out_last;
  logic         parity_ok;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cnu_serial #(.DEG(DEG), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_last  (out_last),
    .parity_ok (parity_ok)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1, "watchdog");
  end

  // Reference: R_j = (XOR of other signs) * min over other |Q_k| (saturated);
  // parity is even count of negative Q.
  function automatic void model(input qarr_t q, output qarr_t r, output bit par);
    longint mx;
    bit     all_sgn;
    mx      = (longint'(1) <<< (W - 1)) - 1;
    all_sgn = 1'b0;
    for (int j = 0; j < DEG; j++) begin
      bit     s;
      longint m;
      s = 1'b0;
      m = mx;
      for (int k = 0; k < DEG; k++) begin
        if (k != j) begin
          longint v, a;
          v = longint'($signed(q[k]));
          s ^= (v < 0);
          a = (v < 0) ? -v : v;
          if (a > mx) a = mx;
          if (a < m) m = a;
        end
      end
      r[j] = W'(s ? -m : m);
      all_sgn ^= q[j][W-1];
    end
    par = ~all_sgn;
  endfunction

  task automatic send_q(input logic [W-1:0] q, input int gap, input string name);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready collect: got %b required 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_q     = q;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_check(input qarr_t q, input qarr_t exp, input bit exp_par, input string name,
                           input int stall_at, input int stall_n, input bit rnd);
    int j, cyc, stalled;
    bit rdy;
    for (int i = 0; i < DEG; i++) send_q(q[i], rnd ? int'($urandom_range(0, 2)) : 0, name);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s latency out_valid: got %b required 1", name, out_valid);
    end
    j = 0; cyc = 0; stalled = 0;
    while (j < DEG && cyc < 400) begin
      tests++;
      if (out_r !== exp[j] || out_last !== (j == DEG - 1) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s out[%0d]: got r=%0d last=%b in_rdy=%b vld=%b required r=%0d last=%b in_rdy=0 vld=1",
                 name, j, $signed(out_r), out_last, in_ready, out_valid, $signed(exp[j]), (j == DEG - 1));
      end
      if (j == stall_at && stalled < stall_n) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      in_valid  = 1'b1;           // must be ignored while emitting
      in_q      = $urandom;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (rdy) j++;
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (j != DEG) begin
      fails++;
      $display("FAIL %s emit timeout: got %0d outputs required %0d", name, j, DEG);
    end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || parity_ok !== exp_par) begin
      fails++;
      $display("FAIL %s after check: got in_rdy=%b vld=%b parity_ok=%b required 1 0 %b",
               name, in_ready, out_valid, parity_ok, exp_par);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_q = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_r !== '0 || parity_ok !== 1'b0) begin
      fails++;
      $display("FAIL reset: got in_rdy=%b vld=%b last=%b r=%h par=%b required 1 0 0 0 0",
               in_ready, out_valid, out_last, out_r, parity_ok);
    end
  endtask

  task automatic test_directed();
    qarr_t q, e;
    q = '{W'(-4), W'(10), W'(5), W'(-6), W'(7), W'(8)};
    e = '{W'(-5), W'(4), W'(4), W'(-4), W'(4), W'(4)};
    run_check(q, e, 1'b1, "basic", -1, 0, 1'b0);
    q = '{W'(-4), W'(1), W'(-11), W'(-6), W'(7), W'(6)};
    e = '{W'(1), W'(-4), W'(1), W'(1), W'(-1), W'(-1)};
    run_check(q, e, 1'b0, "odd_parity", -1, 0, 1'b0);
    q = '{W'(3), W'(3), W'(3), W'(3), W'(3), W'(3)};
    e = '{W'(3), W'(3), W'(3), W'(3), W'(3), W'(3)};
    run_check(q, e, 1'b1, "tie", -1, 0, 1'b0);
    q = '{32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    e = '{32'h7FFFFFFF, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001};
    run_check(q, e, 1'b0, "saturate", -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    qarr_t q, e;
    q = '{W'(-4), W'(10), W'(5), W'(-6), W'(7), W'(8)};
    e = '{W'(-5), W'(4), W'(4), W'(-4), W'(4), W'(4)};
    run_check(q, e, 1'b1, "backpressure", 1, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    qarr_t q, e;
    send_q(W'(-1), 0, "abort");
    send_q(W'(2), 0, "abort");
    send_q(W'(-3), 0, "abort");
    in_valid = 1'b1; in_q = W'(-9); rst = 1'b1;   // reset wins over this handshake
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || parity_ok !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid state: got in_rdy=%b vld=%b par=%b required 1 0 0", in_ready, out_valid, parity_ok);
    end
    q = '{W'(-4), W'(10), W'(5), W'(-6), W'(7), W'(8)};
    e = '{W'(-5), W'(4), W'(4), W'(-4), W'(4), W'(4)};
    run_check(q, e, 1'b1, "after_reset", -1, 0, 1'b0);
  endtask

  task automatic test_random();
    qarr_t q, e;
    bit    p;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEG; i++) begin
        case ($urandom_range(0, 3))
          0:       q[i] = W'(int'($urandom_range(0, 15)) - 8);   // dense ties
          1:       q[i] = $urandom;
          2:       q[i] = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
          default: q[i] = W'(int'($urandom_range(0, 2000)) - 1000);
        endcase
      end
      model(q, e, p);
      run_check(q, e, p, "random", int'($urandom_range(0, DEG - 1)), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_q = '0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
